pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the RISC core's fetch stage. It produces the fetch address each cycle and steps it by a fixed increment. On top of that it supports pipeline stalls, branch/jump redirects, a trap vector, and a halt/resume state machine. A valid flag qualifies the address, and misaligned redirect targets are checked.

---
 rtl/pc_sequencer.sv | 127 ++++++++++++
 tb/tb_pc_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: steps by INCREMENT, honours stall, redirect, trap and halt/resume.
// Build option: define PC_MISALIGN_TRAP_EN to trap misaligned redirects instead of truncating them.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_BOOT | first cycle after reset, pc not yet fetchable
//   ST_RUN  | normal fetch, pc advances or follows redirect/trap
//   ST_HALT | debug halt, pc frozen until resume_i or trap_i
module pc_sequencer #(
   parameter int unsigned ARCHITECTURE = 32,
   parameter int unsigned INCREMENT    = 4,
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    stall_i,
   input  logic                    redirect_valid_i,
   input  logic [ARCHITECTURE-1:0] redirect_target_i,
   input  logic                    trap_i,
   input  logic                    halt_i,
   input  logic                    resume_i,
   output logic [ARCHITECTURE-1:0] pc_o,
   output logic                    pc_valid_o,
   output logic [ARCHITECTURE-1:0] pc_prev_o,
   output logic                    misaligned_o
);

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   localparam logic [ARCHITECTURE-1:0] RST_PC     = ARCHITECTURE'(RESET_VECTOR);
   localparam logic [ARCHITECTURE-1:0] TRAP_PC    = ARCHITECTURE'(TRAP_VECTOR);
   localparam logic [ARCHITECTURE-1:0] STEP       = ARCHITECTURE'(INCREMENT);
   // INCREMENT is a power of two, so INCREMENT-1 selects exactly the alignment bits.
   localparam logic [ARCHITECTURE-1:0] ALIGN_MASK = ARCHITECTURE'(INCREMENT - 1);

   logic [1:0]              state_q, state_d;
   logic [ARCHITECTURE-1:0] pc_q, pc_d;
   logic [ARCHITECTURE-1:0] prev_q;
   logic                    valid_q;
   logic                    redir_misaligned;
   logic [ARCHITECTURE-1:0] redir_aligned_tgt;

   assign redir_misaligned  = |(redirect_target_i & ALIGN_MASK);
   assign redir_aligned_tgt = redirect_target_i & ~ALIGN_MASK;

`ifdef PC_MISALIGN_TRAP_EN
   logic mis_d, mis_q;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
`ifdef PC_MISALIGN_TRAP_EN
      mis_d   = 1'b0;
`endif
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (trap_i) begin
               pc_d = TRAP_PC;
            end else if (redirect_valid_i) begin
               if (!redir_misaligned) begin
                  pc_d = redirect_target_i;
               end else begin
`ifdef PC_MISALIGN_TRAP_EN
                  pc_d  = TRAP_PC;
                  mis_d = 1'b1;
`else
                  pc_d  = redir_aligned_tgt;
`endif
               end
            end else if (halt_i) begin
               state_d = ST_HALT;
            end else if (!stall_i) begin
               pc_d = pc_q + STEP;
            end
         end
         ST_HALT: begin
            if (trap_i) begin
               pc_d    = TRAP_PC;
               state_d = ST_RUN;
            end else if (resume_i) begin
               state_d = ST_RUN;
            end
         end
         // Unused encoding: restart cleanly through BOOT.
         default: state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_BOOT;
         pc_q    <= RST_PC;
         prev_q  <= RST_PC;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         if (pc_d != pc_q) begin
            prev_q <= pc_q;
         end
         valid_q <= (state_d == ST_RUN);
      end
   end

`ifdef PC_MISALIGN_TRAP_EN
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mis_q <= 1'b0;
      end else begin
         mis_q <= mis_d;
      end
   end
   assign misaligned_o = mis_q;
`else
   assign misaligned_o = 1'b0;
`endif

   assign pc_o       = pc_q;
   assign pc_prev_o  = prev_q;
   assign pc_valid_o = valid_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; expectations queued at drive time, checked after each edge.
module tb_pc_sequencer;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        stall_i, redirect_valid_i, trap_i, halt_i, resume_i;
   logic [31:0] redirect_target_i;
   logic [31:0] pc_o, pc_prev_o;
   logic        pc_valid_o, misaligned_o;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic        valid;
      logic [31:0] prev;
      logic        mis;
   } exp_t;

   exp_t sb[$];

   pc_sequencer dut (
      .clk_i             (clk_i),
      .rst_n_i           (rst_n_i),
      .stall_i           (stall_i),
      .redirect_valid_i  (redirect_valid_i),
      .redirect_target_i (redirect_target_i),
      .trap_i            (trap_i),
      .halt_i            (halt_i),
      .resume_i          (resume_i),
      .pc_o              (pc_o),
      .pc_valid_o        (pc_valid_o),
      .pc_prev_o         (pc_prev_o),
      .misaligned_o      (misaligned_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic push(input string tag, input logic [31:0] pc, input logic v,
                       input logic [31:0] prev, input logic mis);
      exp_t e;
      e.tag = tag; e.pc = pc; e.valid = v; e.prev = prev; e.mis = mis;
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      total++;
      assert (sb.size() > 0) else begin
         bad++;
         $error("FAIL scoreboard: observed empty queue, expected an entry");
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         assert (pc_o === e.pc) else begin
            bad++; $error("FAIL %s pc: observed %h expected %h", e.tag, pc_o, e.pc);
         end
         total++;
         assert (pc_valid_o === e.valid) else begin
            bad++; $error("FAIL %s valid: observed %b expected %b", e.tag, pc_valid_o, e.valid);
         end
         total++;
         assert (pc_prev_o === e.prev) else begin
            bad++; $error("FAIL %s prev: observed %h expected %h", e.tag, pc_prev_o, e.prev);
         end
         total++;
         assert (misaligned_o === e.mis) else begin
            bad++; $error("FAIL %s misaligned: observed %b expected %b", e.tag, misaligned_o, e.mis);
         end
      end
   endtask

   task automatic drive(input logic st, input logic rv, input logic [31:0] tgt,
                        input logic tr, input logic hl, input logic rs);
      stall_i = st; redirect_valid_i = rv; redirect_target_i = tgt;
      trap_i = tr; halt_i = hl; resume_i = rs;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
      pop_check();
   endtask

   logic [31:0] mis_pc, mis_next, pre_halt_prev;
   logic        mis_flag;

   initial begin
`ifdef PC_MISALIGN_TRAP_EN
      mis_pc = 32'h100; mis_next = 32'h104; mis_flag = 1'b1;
`else
      mis_pc = 32'h1000; mis_next = 32'h1004; mis_flag = 1'b0;
`endif
      rst_n_i = 1'b0;
      drive(0, 0, 32'h0, 0, 0, 0);
      repeat (2) @(posedge clk_i);
      #1;
      push("reset", 32'h0, 0, 32'h0, 0); pop_check();

      // release mid-cycle; first edge only leaves BOOT
      rst_n_i = 1'b1;
      push("boot", 32'h0, 0, 32'h0, 0); pop_check();
      push("run0", 32'h0, 1, 32'h0, 0); tick();
      push("run4", 32'h4, 1, 32'h0, 0); tick();
      push("run8", 32'h8, 1, 32'h4, 0); tick();
      push("runC", 32'hC, 1, 32'h8, 0); tick();
      push("run10", 32'h10, 1, 32'hC, 0); tick();

      drive(1, 0, 32'h0, 0, 0, 0);
      push("stall1", 32'h10, 1, 32'hC, 0); tick();
      push("stall2", 32'h10, 1, 32'hC, 0); tick();
      drive(1, 1, 32'h200, 0, 0, 0);
      push("stall_redir", 32'h200, 1, 32'h10, 0); tick();

      drive(0, 1, 32'h40, 1, 1, 0);
      push("trap_prio", 32'h100, 1, 32'h200, 0); tick();
      drive(0, 0, 32'h0, 0, 0, 0);
      push("trap_run", 32'h104, 1, 32'h100, 0); tick();

      drive(0, 1, 32'h1002, 0, 0, 0);
      push("misalign", mis_pc, 1, 32'h104, mis_flag); tick();
      drive(0, 0, 32'h0, 0, 0, 0);
      push("misalign_after", mis_next, 1, mis_pc, 0); tick();

      drive(0, 1, 32'h20, 0, 0, 0);
      pre_halt_prev = mis_next;
      push("to20", 32'h20, 1, pre_halt_prev, 0); tick();
      drive(0, 0, 32'h0, 0, 1, 0);
      push("halt", 32'h20, 0, pre_halt_prev, 0); tick();
      // HALT ignores stall, halt and redirect
      drive(1, 1, 32'h80, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         push("halt_idle", 32'h20, 0, pre_halt_prev, 0); tick();
      end
      drive(0, 0, 32'h0, 0, 0, 1);
      push("resume", 32'h20, 1, pre_halt_prev, 0); tick();
      drive(0, 0, 32'h0, 0, 0, 0);
      push("resume_step", 32'h24, 1, 32'h20, 0); tick();
      drive(0, 0, 32'h0, 0, 1, 0);
      push("halt2", 32'h24, 0, 32'h20, 0); tick();
      drive(0, 0, 32'h0, 1, 0, 0);
      push("halt_trap", 32'h100, 1, 32'h24, 0); tick();

      drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
      push("wrap_set", 32'hFFFF_FFFC, 1, 32'h100, 0); tick();
      drive(0, 0, 32'h0, 0, 0, 0);
      push("wrap", 32'h0, 1, 32'hFFFF_FFFC, 0); tick();
      push("wrap_next", 32'h4, 1, 32'h0, 0); tick();

      // asynchronous reset mid-cycle while running
      #2;
      rst_n_i = 1'b0;
      #1;
      push("async_rst_run", 32'h0, 0, 32'h0, 0); pop_check();
      rst_n_i = 1'b1;
      push("boot2", 32'h0, 1, 32'h0, 0); tick();
      drive(0, 0, 32'h0, 0, 1, 0);
      push("halt3", 32'h0, 0, 32'h0, 0); tick();
      drive(0, 1, 32'h300, 1, 0, 0);
      push("halt_trap2", 32'h100, 1, 32'h0, 0); tick();
      drive(0, 0, 32'h0, 0, 1, 0);
      push("halt4", 32'h100, 0, 32'h0, 0); tick();
      #2;
      rst_n_i = 1'b0;
      #1;
      push("async_rst_halt", 32'h0, 0, 32'h0, 0); pop_check();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
